// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg: shared constants and helpers for the memory-port arbiter.
//   - FSM state encodings (IDLE, BUSY_IF, BUSY_LS, DONE)
//   - grant identifiers (GNT_IF, GNT_LS)
//   - rr_pick(): round-robin choice between the fetch and load/store requesters
package mem_arbiter_pkg;

    localparam logic [1:0] IDLE    = 2'b00;
    localparam logic [1:0] BUSY_IF = 2'b01;
    localparam logic [1:0] BUSY_LS = 2'b10;
    localparam logic [1:0] DONE    = 2'b11;

    localparam logic GNT_IF = 1'b0;
    localparam logic GNT_LS = 1'b1;

    // A tie goes to the port that was not granted last; a lone requester always wins.
    function automatic logic rr_pick(input logic if_v, input logic ls_v, input logic last);
        logic gnt;
        if (if_v && ls_v) begin
            gnt = (last == GNT_LS) ? GNT_IF : GNT_LS;
        end else if (if_v) begin
            gnt = GNT_IF;
        end else begin
            gnt = GNT_LS;
        end
        return gnt;
    endfunction

endpackage

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one memory port between instruction fetch (read-only) and the
// load/store unit (read/write). Round-robin, one transaction at a time.
// Ports:
//   clk, rst            clock, asynchronous active-low reset
//   if_*                fetch request (valid/addr) and response (done pulse, held rdata)
//   ls_*                load/store request (valid/we/addr/wdata/wstrb) and response
//   err                 pulse alongside a done that was caused by a memory timeout
//   mem_*               registered memory request; mem_ready/mem_rdata from memory
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int TIMEOUT    = 64
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    if_valid,
    input  logic [ADDR_WIDTH-1:0]   if_addr,
    output logic                    if_done,
    output logic [DATA_WIDTH-1:0]   if_rdata,
    input  logic                    ls_valid,
    input  logic                    ls_we,
    input  logic [ADDR_WIDTH-1:0]   ls_addr,
    input  logic [DATA_WIDTH-1:0]   ls_wdata,
    input  logic [DATA_WIDTH/8-1:0] ls_wstrb,
    output logic                    ls_done,
    output logic [DATA_WIDTH-1:0]   ls_rdata,
    output logic                    err,
    output logic                    mem_req,
    output logic                    mem_we,
    output logic [ADDR_WIDTH-1:0]   mem_addr,
    output logic [DATA_WIDTH-1:0]   mem_wdata,
    output logic [DATA_WIDTH/8-1:0] mem_wstrb,
    input  logic                    mem_ready,
    input  logic [DATA_WIDTH-1:0]   mem_rdata
);

    localparam int               CNT_W   = $clog2(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT - 1);

    logic [1:0]              r_state;
    logic                    r_last;
    logic [CNT_W-1:0]        r_cnt;
    logic                    r_mem_req;
    logic                    r_mem_we;
    logic [ADDR_WIDTH-1:0]   r_mem_addr;
    logic [DATA_WIDTH-1:0]   r_mem_wdata;
    logic [DATA_WIDTH/8-1:0] r_mem_wstrb;
    logic                    r_if_done;
    logic                    r_ls_done;
    logic                    r_err;
    logic [DATA_WIDTH-1:0]   r_if_rdata;
    logic [DATA_WIDTH-1:0]   r_ls_rdata;

    logic w_gnt;

    always_comb begin
        w_gnt = rr_pick(if_valid, ls_valid, r_last);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= IDLE;
            r_last      <= GNT_LS;
            r_cnt       <= '0;
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_mem_wstrb <= '0;
            r_if_done   <= 1'b0;
            r_ls_done   <= 1'b0;
            r_err       <= 1'b0;
            r_if_rdata  <= '0;
            r_ls_rdata  <= '0;
        end else begin
            // Done/err are single-cycle pulses; they are only set on the completing edge.
            r_if_done <= 1'b0;
            r_ls_done <= 1'b0;
            r_err     <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (if_valid || ls_valid) begin
                        r_last    <= w_gnt;
                        r_cnt     <= '0;
                        r_mem_req <= 1'b1;
                        if (w_gnt == GNT_IF) begin
                            r_mem_addr  <= if_addr;
                            r_mem_we    <= 1'b0;
                            r_mem_wdata <= '0;
                            r_mem_wstrb <= '0;
                            r_state     <= BUSY_IF;
                        end else begin
                            r_mem_addr  <= ls_addr;
                            r_mem_we    <= ls_we;
                            r_mem_wdata <= ls_wdata;
                            r_mem_wstrb <= ls_we ? ls_wstrb : '0;
                            r_state     <= BUSY_LS;
                        end
                    end
                end
                BUSY_IF, BUSY_LS: begin
                    if (mem_ready) begin
                        // A ready on the timeout cycle still counts as a normal completion.
                        r_mem_req <= 1'b0;
                        r_state   <= DONE;
                        if (r_state == BUSY_IF) begin
                            r_if_done  <= 1'b1;
                            r_if_rdata <= mem_rdata;
                        end else begin
                            r_ls_done <= 1'b1;
                            if (!r_mem_we) begin
                                r_ls_rdata <= mem_rdata;
                            end
                        end
                    end else if (r_cnt == CNT_MAX) begin
                        r_mem_req <= 1'b0;
                        r_err     <= 1'b1;
                        r_state   <= DONE;
                        if (r_state == BUSY_IF) begin
                            r_if_done <= 1'b1;
                        end else begin
                            r_ls_done <= 1'b1;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                // No grant from DONE: gives the requester a cycle to drop valid.
                DONE:    r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

    assign if_done   = r_if_done;
    assign if_rdata  = r_if_rdata;
    assign ls_done   = r_ls_done;
    assign ls_rdata  = r_ls_rdata;
    assign err       = r_err;
    assign mem_req   = r_mem_req;
    assign mem_we    = r_mem_we;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign mem_wstrb = r_mem_wstrb;

endmodule
